sram_pixel_write_arbiter: RTL and testbench
===========================================

// Module: sram_pixel_write_arbiter
// PURPOSE
//  Shares write port 1 of the 128K x 8 on-chip pixel SRAM between N_REQ pixel writers (DDA plotters).
//  Arbitration is round-robin. Each writer presents {x, y, color} on a valid/ready handshake.
//  Address packing: {y[7:0], x[8:0]} (17 bits). Port 2 stays with the video scan-out reader.
//  An optional built-in screen-clear sequencer is provided (see CONFIGURATION).
// PARAMETERS
//  N_REQ   4    number of pixel-writer requesters (2..8)
//  H_RES   320  visible width; writes with x >= H_RES are dropped
//  V_RES   240  visible height; writes with y >= V_RES are dropped
// PORTS
//  clk             in   1        system clock
//  reset           in   1        asynchronous, active-high reset
//  req_valid       in   N_REQ    per-requester pixel valid
//  req_ready       out  N_REQ    per-requester accept (combinational; one-hot or zero)
//  req_x           in   N_REQ*9  packed x, requester i at [9i+8:9i]
//  req_y           in   N_REQ*8  packed y
//  req_color       in   N_REQ*8  packed 8-bit colour
//  clear_req       in   1        one-cycle pulse: fill the visible area with clear_color
//  clear_color     in   8        fill colour, sampled on the clear_req accept cycle
//  clear_busy      out  1        high while a clear is in progress
//  sram_address    out  17       to SRAM s1 address
//  sram_chipselect out  1        to SRAM s1 chipselect
//  sram_write      out  1        to SRAM s1 write
//  sram_writedata  out  8        to SRAM s1 writedata
//  sram_clken      out  1        to SRAM s1 clken; constant 1
//  drop_count      out  16       saturating count of out-of-bounds pixels dropped
// BEHAVIOUR
//  - Reset values: sram_address = 0, sram_chipselect = 0, sram_write = 0, sram_writedata = 0,
//    clear_busy = 0, drop_count = 0, rr pointer = 0, state = IDLE. req_ready is 0 during reset.
//  - States: IDLE (arbitrate) and CLEAR (fill sequencer). No other states.
//  - IDLE: grant goes to the first i with req_valid[i], searching from ptr upward (mod N_REQ).
//    req_ready[i] = grant[i]. Transfer occurs when valid & ready. On transfer, ptr <= i+1 (mod N_REQ).
//  - Write latency is 1: the transfer in cycle T drives a registered write in cycle T+1:
//    chipselect = write = 1 with addr = {y, x} and writedata = colour. At most one write per cycle.
//    Back-to-back grants give one write every cycle.
//  - Out of bounds (x >= H_RES or y >= V_RES): the pixel is still accepted (ready = 1) and ptr
//    still advances. No SRAM write is issued. drop_count increments and saturates at 16'hFFFF.
//  - Idle cycles: sram_chipselect = sram_write = 0. sram_address and sram_writedata hold their last values.
//  - clear_req in IDLE takes priority over all req_valid in the same cycle: no grant that cycle.
//    Next state is CLEAR and clear_busy <= 1.
//  - CLEAR: writes clear_color once per cycle, row-major: y = 0..V_RES-1, x = 0..H_RES-1.
//    Total H_RES*V_RES writes. req_ready = 0 throughout; requests are stalled, not dropped.
//    After the write of (H_RES-1, V_RES-1): state <= IDLE and clear_busy <= 0 in the following cycle.
//  - clear_req while in CLEAR is ignored, with no restart.
//  - Reset asserted mid-clear or mid-write aborts immediately to reset values. No partial write
//    is held or replayed.
//  - The arbiter never drives port 2. Same-address read/write collisions with scan-out are
//    acceptable (the SRAM is configured as don't-care for mixed-port read-during-write).
// CONFIGURATION
//  SRAM_ARB_CLEAR_EN defined: CLEAR state and sequencer are present, as described above.
//  SRAM_ARB_CLEAR_EN undefined: there is no CLEAR state. clear_req and clear_color are ignored.
//    clear_busy is tied 0. The arbiter is permanently in IDLE behaviour.
// STRUCTURE
//  Package sram_arb_pkg holds:
//    ADDR_W = 17, X_W = 9, Y_W = 8, PIX_W = 8
//    state enum {IDLE, CLEAR}
//    function pack_addr(x, y) returning {y, x}
//  Sub-module rr_arbiter: N_REQ-wide round-robin grant with ptr register, req -> one-hot grant,
//    and an advance input.
//  Top level contains: bounds check, write register stage, drop counter, clear x/y counters.
// TESTING
//  1. Single request: req 0 valid, x = 5, y = 3, color = 8'hA5 -> ready[0] in cycle T.
//     Cycle T+1: cs = wr = 1, addr = 17'h00605, data = A5.
//  2. All 4 requesters valid continuously, ptr = 0 -> grants 0,1,2,3,0,... with one write per cycle
//     and no bubbles.
//  3. Out of bounds: x = 320, y = 0 -> ready = 1, no cs/wr, drop_count 0 -> 1.
//     Preload the counter to FFFF -> it stays FFFF.
//  4. Clear (macro on): clear_req plus req 1 valid in the same cycle -> no grant.
//     Exactly 76800 writes of clear_color, first addr 0, last addr {8'd239, 9'd319}.
//     Req 1 is granted in the first cycle after clear_busy falls.
//  5. Reset mid-clear at write 1000 -> cs = wr = busy = 0 immediately. After release: IDLE, ptr = 0.
//  6. Macro off: clear_req pulse -> clear_busy stays 0. Requests are served normally in the same cycle.

Source files
------------

// File: rtl/sram_pixel_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared widths, FSM state type and address packing for the pixel SRAM
// write-port arbiter.
//   ADDR_W : SRAM word address width (128K x 8)
//   X_W    : pixel x coordinate width
//   Y_W    : pixel y coordinate width
//   PIX_W  : pixel colour width
// ---------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int ADDR_W = 17;
   localparam int X_W    = 9;
   localparam int Y_W    = 8;
   localparam int PIX_W  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Row-major framebuffer layout: y selects a 512-byte row, x the byte.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/sram_pixel_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: one-hot grant to the first asserted request at or
// above the pointer (wrapping). The pointer moves past the granted requester
// when advance is high.
//   clk     : clock
//   reset   : asynchronous active-high reset (pointer -> 0)
//   req     : request vector
//   advance : a transfer to the current grant happened this cycle
//   grant   : one-hot grant, or zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned N_REQ = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] gidx;
   logic             found;
   int unsigned      idx;

   always_comb begin
      grant = '0;
      gidx  = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr_q) + k) % N_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            gidx       = PTR_W'(idx);
            found      = 1'b1;
         end
      end
   end

   // Wrap explicitly so non-power-of-two N_REQ never points past the last requester.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/sram_pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// sram_pixel_write_arbiter
// Shares SRAM write port 1 between N_REQ pixel writers with round-robin
// arbitration, a one-cycle registered write stage, bounds clipping with a
// saturating drop counter, and an optional screen-clear sequencer.
// Build option: define SRAM_ARB_CLEAR_EN to include the CLEAR sequencer;
// otherwise clear_req/clear_color are ignored and clear_busy is tied 0.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   req_valid/ready  : per-requester handshake (ready is combinational, one-hot)
//   req_x/y/color    : packed per-requester pixel (9/8/8 bits per requester)
//   clear_req        : pulse to start filling the visible area
//   clear_color      : fill colour, captured when clear_req is accepted
//   clear_busy       : fill in progress
//   sram_*           : SRAM port 1 address/chipselect/write/writedata/clken
//   drop_count       : saturating count of clipped pixels
// ---------------------------------------------------------------------------
module sram_pixel_write_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned H_RES = 320,
   parameter int unsigned V_RES = 240
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*X_W-1:0]   req_x,
   input  logic [N_REQ*Y_W-1:0]   req_y,
   input  logic [N_REQ*PIX_W-1:0] req_color,
   input  logic                   clear_req,
   input  logic [PIX_W-1:0]       clear_color,
   output logic                   clear_busy,
   output logic [ADDR_W-1:0]      sram_address,
   output logic                   sram_chipselect,
   output logic                   sram_write,
   output logic [PIX_W-1:0]       sram_writedata,
   output logic                   sram_clken,
   output logic [15:0]            drop_count
);

   logic [N_REQ-1:0]  arb_req;
   logic [N_REQ-1:0]  grant;
   logic              arb_en;
   logic              xfer;
   logic              in_bounds;
   logic [X_W-1:0]    sel_x;
   logic [Y_W-1:0]    sel_y;
   logic [PIX_W-1:0]  sel_c;

   logic              clr_active;
   logic              clr_start;
   logic [X_W-1:0]    cx_q;
   logic [Y_W-1:0]    cy_q;
   logic [PIX_W-1:0]  ccol_q;

   logic              wr_q,   wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PIX_W-1:0]  data_q, data_d;
   logic [15:0]       drop_q, drop_d;

   // ------------------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------------------
`ifdef SRAM_ARB_CLEAR_EN
   state_t           state_q, state_d;
   logic [X_W-1:0]   cx_d;
   logic [Y_W-1:0]   cy_d;
   logic [PIX_W-1:0] ccol_d;

   always_comb begin
      state_d   = state_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      ccol_d    = ccol_q;
      clr_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               cx_d      = '0;
               cy_d      = '0;
               ccol_d    = clear_color;
               clr_start = 1'b1;
            end
         end
         CLEAR: begin
            // clear_req is deliberately not looked at here: no restart.
            if (cx_q == X_W'(H_RES - 1)) begin
               cx_d = '0;
               if (cy_q == Y_W'(V_RES - 1)) begin
                  cy_d    = '0;
                  state_d = IDLE;
               end else begin
                  cy_d = cy_q + 1'b1;
               end
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         ccol_q  <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         ccol_q  <= ccol_d;
      end
   end

   assign clr_active = (state_q == CLEAR);
`else
   logic unused_clear;
   assign unused_clear = ^{clear_req, clear_color};
   assign clr_active   = 1'b0;
   assign clr_start    = 1'b0;
   assign cx_q         = '0;
   assign cy_q         = '0;
   assign ccol_q       = '0;
`endif

   assign clear_busy = clr_active;

   // ------------------------------------------------------------------------
   // Arbitration: a clear (starting or running) and reset both mask requests
   // ------------------------------------------------------------------------
   assign arb_en  = !reset && !clr_active && !clr_start;
   assign arb_req = arb_en ? req_valid : '0;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (arb_req),
      .advance (xfer),
      .grant   (grant)
   );

   assign req_ready = grant;
   assign xfer      = |grant;

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      sel_c = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant[i]) begin
            sel_x = req_x[X_W*i +: X_W];
            sel_y = req_y[Y_W*i +: Y_W];
            sel_c = req_color[PIX_W*i +: PIX_W];
         end
      end
   end

   assign in_bounds = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);

   // ------------------------------------------------------------------------
   // Write register stage and drop counter
   // ------------------------------------------------------------------------
   always_comb begin
      wr_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      drop_d = drop_q;
      if (clr_active) begin
         wr_d   = 1'b1;
         addr_d = pack_addr(cx_q, cy_q);
         data_d = ccol_q;
      end else if (xfer) begin
         if (in_bounds) begin
            wr_d   = 1'b1;
            addr_d = pack_addr(sel_x, sel_y);
            data_d = sel_c;
         end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         drop_q <= '0;
      end else begin
         wr_q   <= wr_d;
         addr_q <= addr_d;
         data_q <= data_d;
         drop_q <= drop_d;
      end
   end

   assign sram_chipselect = wr_q;
   assign sram_write      = wr_q;
   assign sram_address    = addr_q;
   assign sram_writedata  = data_q;
   assign sram_clken      = 1'b1;
   assign drop_count      = drop_q;

endmodule

// File: tb/tb_sram_pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_pixel_write_arbiter
// Directed bench for the pixel SRAM write arbiter (N_REQ = 4, 320x240).
// Build option SRAM_ARB_CLEAR_EN selects the clear-sequencer scenarios;
// without it the clear-ignored and drop-saturation scenarios run.
// ---------------------------------------------------------------------------
module tb_sram_pixel_write_arbiter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [35:0] req_x;
   logic [31:0] req_y;
   logic [31:0] req_color;
   logic        clear_req;
   logic [7:0]  clear_color;
   logic        clear_busy;
   logic [16:0] sram_address;
   logic        sram_chipselect;
   logic        sram_write;
   logic [7:0]  sram_writedata;
   logic        sram_clken;
   logic [15:0] drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   sram_pixel_write_arbiter #(
      .N_REQ (N),
      .H_RES (320),
      .V_RES (240)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_x           (req_x),
      .req_y           (req_y),
      .req_color       (req_color),
      .clear_req       (clear_req),
      .clear_color     (clear_color),
      .clear_busy      (clear_busy),
      .sram_address    (sram_address),
      .sram_chipselect (sram_chipselect),
      .sram_write      (sram_write),
      .sram_writedata  (sram_writedata),
      .sram_clken      (sram_clken),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [8:0]  x;
      logic [7:0]  y;
      logic [7:0]  c;
      logic [3:0]  rdy;
      logic        wr;
      logic [16:0] addr;
      logic [7:0]  data;
      logic [15:0] drop;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every requester sees the same coordinates; colour = c + index so the
   // written data identifies which requester won.
   task automatic set_pix(input logic [3:0] v, input logic [8:0] x, input logic [7:0] y,
                          input logic [7:0] c);
      req_valid = v;
      for (int i = 0; i < N; i++) begin
         req_x[9*i +: 9]     = x;
         req_y[8*i +: 8]     = y;
         req_color[8*i +: 8] = c + 8'(i);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      clear_req = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int wcount;
      int bad;
      int leak;
      int cyc;
      logic [16:0] first_a;
      logic [16:0] last_a;
      int cs_seen;

      vt[0]  = '{4'b0001, 9'd5,   8'd3,   8'hA5, 4'b0001, 1'b1, 17'h00605, 8'hA5, 16'd0};
      vt[1]  = '{4'b0000, 9'd5,   8'd3,   8'hA5, 4'b0000, 1'b0, 17'h00605, 8'hA5, 16'd0};
      vt[2]  = '{4'b0001, 9'd10,  8'd20,  8'h10, 4'b0001, 1'b1, 17'h0280A, 8'h10, 16'd0};
      vt[3]  = '{4'b1111, 9'd1,   8'd1,   8'h20, 4'b0010, 1'b1, 17'h00201, 8'h21, 16'd0};
      vt[4]  = '{4'b1001, 9'd319, 8'd239, 8'h30, 4'b1000, 1'b1, 17'h1DF3F, 8'h33, 16'd0};
      vt[5]  = '{4'b1001, 9'd0,   8'd0,   8'h40, 4'b0001, 1'b1, 17'h00000, 8'h40, 16'd0};
      vt[6]  = '{4'b0100, 9'd320, 8'd0,   8'h50, 4'b0100, 1'b0, 17'h00000, 8'h40, 16'd1};
      vt[7]  = '{4'b0100, 9'd0,   8'd240, 8'h60, 4'b0100, 1'b0, 17'h00000, 8'h40, 16'd2};
      vt[8]  = '{4'b1000, 9'd319, 8'd239, 8'h70, 4'b1000, 1'b1, 17'h1DF3F, 8'h73, 16'd2};
      vt[9]  = '{4'b0010, 9'd319, 8'd0,   8'h80, 4'b0010, 1'b1, 17'h0013F, 8'h81, 16'd2};
      vt[10] = '{4'b0011, 9'd2,   8'd2,   8'h90, 4'b0001, 1'b1, 17'h00402, 8'h90, 16'd2};
      vt[11] = '{4'b0011, 9'd3,   8'd3,   8'hA0, 4'b0010, 1'b1, 17'h00603, 8'hA1, 16'd2};

      // Reset state, with all requesters valid to show ready is held low.
      reset       = 1'b1;
      clear_req   = 1'b0;
      clear_color = 8'h00;
      set_pix(4'b1111, 9'd7, 8'd7, 8'h01);
      tick();
      tick();
      check("rst ready", 32'(req_ready), 32'h0);
      check("rst cs", 32'(sram_chipselect), 32'h0);
      check("rst wr", 32'(sram_write), 32'h0);
      check("rst addr", 32'(sram_address), 32'h0);
      check("rst data", 32'(sram_writedata), 32'h0);
      check("rst busy", 32'(clear_busy), 32'h0);
      check("rst drop", 32'(drop_count), 32'h0);
      check("clken", 32'(sram_clken), 32'h1);
      req_valid = '0;
      reset     = 1'b0;

      // Vector table: arbitration order, write latency, clipping.
      for (int i = 0; i < 12; i++) begin
         set_pix(vt[i].valid, vt[i].x, vt[i].y, vt[i].c);
         #1;
         check($sformatf("v%0d ready", i), 32'(req_ready), 32'(vt[i].rdy));
         tick();
         check($sformatf("v%0d cs", i), 32'(sram_chipselect), 32'(vt[i].wr));
         check($sformatf("v%0d wr", i), 32'(sram_write), 32'(vt[i].wr));
         check($sformatf("v%0d addr", i), 32'(sram_address), 32'(vt[i].addr));
         check($sformatf("v%0d data", i), 32'(sram_writedata), 32'(vt[i].data));
         check($sformatf("v%0d drop", i), 32'(drop_count), 32'(vt[i].drop));
      end

      // All requesters continuously valid from ptr 0: 0,1,2,3,0,... no bubbles.
      do_reset();
      set_pix(4'b1111, 9'd7, 8'd7, 8'hC0);
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("rr%0d ready", k), 32'(req_ready), 32'(1 << (k % 4)));
         tick();
         check($sformatf("rr%0d cs", k), 32'(sram_chipselect), 32'h1);
         check($sformatf("rr%0d addr", k), 32'(sram_address), 32'h00E07);
         check($sformatf("rr%0d data", k), 32'(sram_writedata), 32'(8'hC0 + 8'(k % 4)));
      end
      req_valid = '0;

`ifdef SRAM_ARB_CLEAR_EN
      // Clear with a competing request in the same cycle.
      do_reset();
      set_pix(4'b0010, 9'd9, 8'd9, 8'hE0);
      clear_req   = 1'b1;
      clear_color = 8'h5A;
      #1;
      check("clr prio ready", 32'(req_ready), 32'h0);
      tick();
      clear_req   = 1'b0;
      clear_color = 8'h00;
      check("clr busy rise", 32'(clear_busy), 32'h1);
      check("clr cs start", 32'(sram_chipselect), 32'h0);
      wcount  = 0;
      bad     = 0;
      leak    = 0;
      cyc     = 0;
      first_a = '1;
      last_a  = '0;
      while (cyc < 80000) begin
         if (clear_busy && (req_ready != 4'b0000)) leak++;
         tick();
         cyc++;
         clear_req = 1'b0;
         if (sram_chipselect) begin
            if (wcount == 0) first_a = sram_address;
            last_a = sram_address;
            if (sram_writedata != 8'h5A || !sram_write) bad++;
            wcount++;
            if (wcount == 500) clear_req = 1'b1;
         end
         if (!clear_busy) break;
      end
      check("clr busy fell", 32'(clear_busy), 32'h0);
      check("clr count", 32'(wcount), 32'd76800);
      check("clr first addr", 32'(first_a), 32'h0);
      check("clr last addr", 32'(last_a), 32'h1DF3F);
      check("clr bad data", 32'(bad), 32'h0);
      check("clr ready leak", 32'(leak), 32'h0);
      check("post clr ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      check("post clr cs", 32'(sram_chipselect), 32'h1);
      check("post clr addr", 32'(sram_address), 32'h01209);
      check("post clr data", 32'(sram_writedata), 32'hE1);

      // Reset in the middle of a clear.
      do_reset();
      set_pix(4'b0000, 9'd0, 8'd0, 8'h00);
      clear_req   = 1'b1;
      clear_color = 8'h77;
      tick();
      clear_req = 1'b0;
      wcount    = 0;
      cyc       = 0;
      while (wcount < 1000 && cyc < 2000) begin
         tick();
         cyc++;
         if (sram_chipselect) wcount++;
      end
      check("mid clr count", 32'(wcount), 32'd1000);
      set_pix(4'b1111, 9'd6, 8'd6, 8'h60);
      reset = 1'b1;
      #1;
      check("abort cs", 32'(sram_chipselect), 32'h0);
      check("abort wr", 32'(sram_write), 32'h0);
      check("abort busy", 32'(clear_busy), 32'h0);
      check("abort ready", 32'(req_ready), 32'h0);
      tick();
      reset = 1'b0;
      #1;
      check("after abort ready", 32'(req_ready), 32'h1);
      check("after abort busy", 32'(clear_busy), 32'h0);
      tick();
      req_valid = '0;
      check("after abort data", 32'(sram_writedata), 32'h60);
`else
      // Clear request is ignored: requester served in the same cycle.
      do_reset();
      set_pix(4'b0010, 9'd4, 8'd4, 8'hD0);
      clear_req   = 1'b1;
      clear_color = 8'hFF;
      #1;
      check("noclr ready", 32'(req_ready), 32'h2);
      check("noclr busy", 32'(clear_busy), 32'h0);
      tick();
      clear_req = 1'b0;
      req_valid = '0;
      check("noclr busy2", 32'(clear_busy), 32'h0);
      check("noclr cs", 32'(sram_chipselect), 32'h1);
      check("noclr addr", 32'(sram_address), 32'h00804);
      check("noclr data", 32'(sram_writedata), 32'hD1);

      // Drop counter saturation via a continuous out-of-bounds stream.
      do_reset();
      set_pix(4'b0001, 9'd320, 8'd0, 8'h00);
      cs_seen = 0;
      for (int n = 1; n <= 65535; n++) begin
         tick();
         if (sram_chipselect) cs_seen++;
         if (n == 100) check("drop 100", 32'(drop_count), 32'd100);
      end
      check("drop sat", 32'(drop_count), 32'hFFFF);
      check("drop no cs", 32'(cs_seen), 32'h0);
      tick();
      tick();
      tick();
      check("drop hold", 32'(drop_count), 32'hFFFF);
      req_valid = '0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
